// File: rtl/uart_tx.sv
//==============================================================================
// uart_tx : LSB-first UART transmitter with a one-byte holding register.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_tx #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       tx_busy
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   localparam logic STOP_LAST = (STOP_BITS == 2);

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic        stop_q;
   logic [7:0]  shift_q;
   logic [7:0]  hold_q;
   logic        hold_full_q;
   logic        tx_out_q;
   logic        tx_busy_q;

   logic        xfer;
   logic        at_last_stop;
   logic        to_hold;

   assign xfer         = tx_valid & ~hold_full_q;
   assign at_last_stop = (state_q == STOP) && (stop_q == STOP_LAST);
   // A byte arriving on the last stop edge goes straight to the shifter instead.
   assign to_hold      = xfer && (state_q != IDLE) && !at_last_stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         stop_q      <= 1'b0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         tx_out_q    <= 1'b1;
         tx_busy_q   <= 1'b0;
      end else begin
         if (to_hold) begin
            hold_q      <= tx_data;
            hold_full_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (xfer || hold_full_q) begin
                  shift_q     <= hold_full_q ? hold_q : tx_data;
                  hold_full_q <= 1'b0;
                  state_q     <= START;
                  tx_out_q    <= 1'b0;
                  tx_busy_q   <= 1'b1;
               end
            end

            START: begin
               state_q  <= DATA;
               cnt_q    <= 3'd0;
               tx_out_q <= shift_q[0];
            end

            DATA: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_q  <= PARITY;
                  tx_out_q <= ^shift_q;
`else
                  state_q  <= STOP;
                  stop_q   <= 1'b0;
                  tx_out_q <= 1'b1;
`endif
               end else begin
                  tx_out_q <= shift_q[cnt_q + 3'd1];
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               state_q  <= STOP;
               stop_q   <= 1'b0;
               tx_out_q <= 1'b1;
            end
`endif

            STOP: begin
               if (stop_q == STOP_LAST) begin
                  if (hold_full_q || xfer) begin
                     shift_q     <= hold_full_q ? hold_q : tx_data;
                     hold_full_q <= 1'b0;
                     state_q     <= START;
                     tx_out_q    <= 1'b0;
                  end else begin
                     state_q   <= IDLE;
                     tx_out_q  <= 1'b1;
                     tx_busy_q <= 1'b0;
                  end
               end else begin
                  stop_q <= 1'b1;
               end
            end

            default: begin
               state_q   <= IDLE;
               tx_out_q  <= 1'b1;
               tx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = ~hold_full_q;
   assign tx_out   = tx_out_q;
   assign tx_busy  = tx_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//==============================================================================
// tb_uart_tx : self-checking bench for uart_tx against a frame-queue model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_uart_tx;

   localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int L  = 9 + SB + PAR;
   localparam int L2 = 11 + PAR;

   typedef bit bitq_t[$];

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   wire        tx_ready;
   wire        tx_out;
   wire        tx_busy;

   logic [7:0] d2;
   logic       v2;
   wire        r2;
   wire        o2;
   wire        b2;

   always #5 clk = ~clk;

   uart_tx #(.STOP_BITS(SB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_out   (tx_out),
      .tx_busy  (tx_busy)
   );

   uart_tx #(.STOP_BITS(2)) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (d2),
      .tx_valid (v2),
      .tx_ready (r2),
      .tx_out   (o2),
      .tx_busy  (b2)
   );

   int nchk = 0;
   int nerr = 0;

   // Model: every accepted byte appends its whole frame; the line plays the queue out one bit per cycle.
   bit         exp_q[$];
   logic       exp_out;
   logic       exp_busy;
   logic       exp_ready;
   logic       last_acc;
   logic       line_log[$];
   logic [7:0] rx_q[$];

   function automatic bitq_t frame_bits(input logic [7:0] d, input int sb);
      bitq_t f;
      f.push_back(1'b0);
      for (int i = 0; i < 8; i++) f.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      f.push_back(^d);
`endif
      for (int i = 0; i < sb; i++) f.push_back(1'b1);
      return f;
   endfunction

   task automatic tick();
      logic       acc;
      logic [7:0] d;
      bitq_t      f;
      @(negedge clk);
      acc = tx_valid && exp_ready;
      d   = tx_data;
      @(posedge clk);
      #1;
      if (acc) begin
         f = frame_bits(d, SB);
         foreach (f[j]) exp_q.push_back(f[j]);
      end
      exp_busy  = (exp_q.size() != 0);
      exp_out   = exp_busy ? exp_q.pop_front() : 1'b1;
      exp_ready = (exp_q.size() < L);
      last_acc  = acc;
      line_log.push_back(tx_out);
   endtask

   task automatic decode_log();
      int         i;
      logic [7:0] b;
      i = 0;
      rx_q.delete();
      while (i + 8 < line_log.size()) begin
         if (line_log[i] == 1'b0) begin
            for (int j = 0; j < 8; j++) b[j] = line_log[i + 1 + j];
            rx_q.push_back(b);
            i = i + L;
         end else begin
            i = i + 1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; v2 = 1'b0; d2 = 8'h00;
      exp_q.delete(); exp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nchk++; if (tx_out !== 1'b1) begin nerr++; $display("FAIL reset_out: got %b want 1", tx_out); end
      nchk++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      nchk++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      nchk++; if (o2 !== 1'b1 || r2 !== 1'b1) begin nerr++; $display("FAIL reset_dut2: got out=%b ready=%b want 1,1", o2, r2); end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         nchk++;
         if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
            nerr++; $display("FAIL reset_idle cyc %0d: got out=%b busy=%b want 1,0", i, tx_out, tx_busy);
         end
      end
   endtask

   task automatic test_single();
      int         busy_cnt;
      logic [9:0] obs;
      busy_cnt = 0;
      obs = '0;
      tx_valid = 1'b1; tx_data = 8'hA5;
      tick();
      tx_valid = 1'b0; tx_data = 8'($urandom);
      for (int i = 0; i < L + 4; i++) begin
         if (i > 0) tick();
         if (i < 10) obs[i] = tx_out;
         if (tx_busy === 1'b1) busy_cnt++;
         nchk++; if (tx_out !== exp_out) begin nerr++; $display("FAIL single_out cyc %0d: got %b want %b", i, tx_out, exp_out); end
         nchk++; if (tx_busy !== exp_busy) begin nerr++; $display("FAIL single_busy cyc %0d: got %b want %b", i, tx_busy, exp_busy); end
         nchk++; if (tx_ready !== exp_ready) begin nerr++; $display("FAIL single_ready cyc %0d: got %b want %b", i, tx_ready, exp_ready); end
      end
      nchk++; if (busy_cnt != L) begin nerr++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, L); end
`ifndef UART_TX_PARITY_EN
      nchk++; if (obs !== 10'b1101001010) begin nerr++; $display("FAIL single_seq: got %b want %b", obs, 10'b1101001010); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
      int k, run, max_run;
      k = 0; run = 0; max_run = 0;
      line_log.delete();
      tx_valid = 1'b1; tx_data = bytes[0];
      for (int t = 0; t < 3 * L + 10; t++) begin
         tick();
         if (last_acc) begin
            k++;
            if (k == 2) begin
               nchk++; if (tx_ready !== 1'b0) begin nerr++; $display("FAIL b2b_ready_drop: got %b want 0", tx_ready); end
            end
            if (k < 3) tx_data = bytes[k];
            else tx_valid = 1'b0;
         end
         nchk++; if (tx_out !== exp_out) begin nerr++; $display("FAIL b2b_out cyc %0d: got %b want %b", t, tx_out, exp_out); end
         nchk++; if (tx_busy !== exp_busy) begin nerr++; $display("FAIL b2b_busy cyc %0d: got %b want %b", t, tx_busy, exp_busy); end
         nchk++; if (tx_ready !== exp_ready) begin nerr++; $display("FAIL b2b_ready cyc %0d: got %b want %b", t, tx_ready, exp_ready); end
         run = (tx_busy === 1'b1) ? run + 1 : 0;
         if (run > max_run) max_run = run;
      end
      nchk++; if (max_run != 3 * L) begin nerr++; $display("FAIL b2b_contiguous: got %0d want %0d", max_run, 3 * L); end
      decode_log();
      nchk++; if (rx_q.size() != 3) begin nerr++; $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         nchk++; if (rx_q[i] !== bytes[i]) begin nerr++; $display("FAIL b2b_rx_byte %0d: got %h want %h", i, rx_q[i], bytes[i]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] sent[$];
      logic [7:0] cur;
      line_log.delete();
      for (int t = 0; t < 700; t++) begin
         tx_valid = (sent.size() < 40) && ($urandom_range(0, 3) != 0);
         cur = 8'($urandom);
         tx_data = cur;
         tick();
         if (last_acc) sent.push_back(cur);
         nchk++; if (tx_out !== exp_out) begin nerr++; $display("FAIL rand_out cyc %0d: got %b want %b", t, tx_out, exp_out); end
         nchk++; if (tx_busy !== exp_busy) begin nerr++; $display("FAIL rand_busy cyc %0d: got %b want %b", t, tx_busy, exp_busy); end
         nchk++; if (tx_ready !== exp_ready) begin nerr++; $display("FAIL rand_ready cyc %0d: got %b want %b", t, tx_ready, exp_ready); end
      end
      tx_valid = 1'b0;
      for (int t = 0; t < 2 * L + 2; t++) begin
         tick();
         nchk++; if (tx_out !== exp_out) begin nerr++; $display("FAIL rand_drain_out cyc %0d: got %b want %b", t, tx_out, exp_out); end
      end
      decode_log();
      nchk++; if (rx_q.size() != sent.size()) begin nerr++; $display("FAIL rand_rx_count: got %0d want %0d", rx_q.size(), sent.size()); end
      for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
         nchk++; if (rx_q[i] !== sent[i]) begin nerr++; $display("FAIL rand_rx_byte %0d: got %h want %h", i, rx_q[i], sent[i]); end
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] pb [2] = '{8'h07, 8'h03};
      logic       pe [2] = '{1'b1, 1'b0};
      for (int n = 0; n < 2; n++) begin
         line_log.delete();
         tx_valid = 1'b1; tx_data = pb[n];
         tick();
         tx_valid = 1'b0;
         repeat (L + 1) tick();
         nchk++; if (line_log[9] !== pe[n]) begin nerr++; $display("FAIL parity_bit %h: got %b want %b", pb[n], line_log[9], pe[n]); end
      end
   endtask
`endif

   task automatic test_two_stop_bits();
      logic [7:0] a, b;
      bit         e[$];
      bitq_t      f;
      logic       want;
      a = 8'($urandom); b = 8'($urandom);
      f = frame_bits(a, 2); foreach (f[j]) e.push_back(f[j]);
      f = frame_bits(b, 2); foreach (f[j]) e.push_back(f[j]);
      v2 = 1'b1; d2 = a;
      for (int i = 0; i < 2 * L2 + 3; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) d2 = b;
         if (i == 1) begin
            v2 = 1'b0;
            nchk++; if (r2 !== 1'b0) begin nerr++; $display("FAIL stop2_ready: got %b want 0", r2); end
         end
         want = (i < e.size()) ? e[i] : 1'b1;
         nchk++; if (o2 !== want) begin nerr++; $display("FAIL stop2_out cyc %0d: got %b want %b", i, o2, want); end
         nchk++; if (b2 !== (i < e.size())) begin nerr++; $display("FAIL stop2_busy cyc %0d: got %b want %b", i, b2, (i < e.size())); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] x;
      x = 8'($urandom);
      tx_valid = 1'b1; tx_data = x;
      tick();
      tx_data = 8'($urandom);
      tick();
      tx_valid = 1'b0;
      repeat (4) tick();
      nchk++; if (tx_out !== x[4]) begin nerr++; $display("FAIL midrst_d4: got %b want %b", tx_out, x[4]); end
      nchk++; if (tx_ready !== 1'b0) begin nerr++; $display("FAIL midrst_held: got %b want 0", tx_ready); end
      #2 rst_n = 1'b0;
      #1;
      nchk++; if (tx_out !== 1'b1) begin nerr++; $display("FAIL midrst_out: got %b want 1", tx_out); end
      nchk++; if (tx_busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
      nchk++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
      exp_q.delete(); exp_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         nchk++;
         if (tx_out !== exp_out || tx_busy !== exp_busy || tx_ready !== exp_ready) begin
            nerr++; $display("FAIL midrst_after cyc %0d: got out=%b busy=%b ready=%b want %b,%b,%b",
                             i, tx_out, tx_busy, tx_ready, exp_out, exp_busy, exp_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_two_stop_bits();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

`default_nettype wire
